fir_filter_mac: RTL and testbench
=================================

# fir_filter_mac

Parametrised, time-multiplexed FIR filter for the audio path: N-channel packed samples in, filtered N-channel packed samples out, one shared multiply-accumulate unit. It sits between the audio codec receive deserialiser and the DAC serialiser, and is driven by a one-cycle sample strobe from the LRCK edge detector. Coefficients are run-time loadable and the filter has a bypass mode.

## Interface
- DATA_W, 16, sample width per channel (two's complement)
- COEF_W, 16, coefficient width (signed, Q(COEF_W-FRAC_BITS).FRAC_BITS)
- FRAC_BITS, 14, fractional bits of coefficients
- TAPS, 9, filter length (≥2)
- CHANNELS, 2, channel count; channel 0 occupies the MSBs of packed buses

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sample_valid  in  1  new input frame present
- sample_ready  out  1  block idle; frame accepted when valid&ready
- sample_in  in  CHANNELS*DATA_W  packed input frame
- out_valid  out  1  one-cycle strobe, sample_out updated
- sample_out  out  CHANNELS*DATA_W  packed filtered frame, held between strobes
- bypass  in  1  1 = pass input straight through
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  clog2(TAPS)  tap index
- coef_wr_data  in  COEF_W  coefficient value

## Operation
- Per channel delay line of TAPS entries, x[0] newest; all channels share one coefficient bank h[0..TAPS-1].
- y_c = sat(round(Σ h[k]·x_c[k] >>> FRAC_BITS)); round = add 2^(FRAC_BITS-1) before the arithmetic shift; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Accumulator width ACC_W = DATA_W+COEF_W+clog2(TAPS); no internal overflow is possible.
- FSM: IDLE → MAC → OUT → IDLE.
  - IDLE: sample_ready=1. On valid: shift every delay line by one and load x_c[0] from sample_in; clear acc; go to MAC, or to OUT if bypass.
  - MAC: one product per cycle, channel-major (ch0 taps 0..TAPS-1, then ch1, …); at each channel's last tap, latch the saturated result into that channel's output register and clear acc.
  - OUT: pulse out_valid; return to IDLE.
- Bypass: sample_out = sample_in captured at acceptance; the delay line still shifts so that leaving bypass is glitch-consistent.
- Coefficient writes are accepted only in IDLE; writes in MAC/OUT are dropped. An out-of-range address (≥TAPS) is ignored.
- A write and a sample accepted in the same IDLE cycle: the write lands first, and the frame uses the new coefficient.
- bypass is sampled only at acceptance.

## Timing
- Reset (async, rst=0): FSM=IDLE, sample_ready=1, out_valid=0, sample_out=0, delay lines=0, acc=0, h[0]=2^FRAC_BITS, h[k>0]=0 (identity filter).
- Latency from acceptance edge to out_valid high: TAPS·CHANNELS+1 cycles (19 at defaults); bypass: 1 cycle.
- Throughput: one frame per TAPS·CHANNELS+2 cycles; sample_ready returns high the cycle after out_valid.
- sample_valid while sample_ready=0 is ignored (not queued); upstream must hold off or drop.
- Reset mid-MAC aborts the frame; no out_valid is emitted.
- sample_out changes only on the cycle out_valid asserts.

## Structure
- Shared package fir_pkg: FSM state enum, ACC_W/index width functions, saturate-and-round function, default coefficient constant.
- One sub-module: fir_mac_unit (signed multiply, accumulate, clear, round/saturate output); the FSM, delay lines and coefficient bank stay in the top module.

## Test plan
- Post-reset identity: feed ch0=1000, ch1=-1000 → out_valid at +19 cycles with ch0=1000, ch1=-1000; later frames pass through unchanged.
- Impulse response: load h[k]=k·1024 for k=0..8, feed 16384 then zeros → successive ch0 outputs 0,1024,…,8192 (h[k]·16384>>14), then 0.
- Saturation: all h[k]=16384, feed 32767 for 9 frames → output clamps at 32767; feed -32768 → -32768.
- Rounding: h[0]=8193, input 2 → (16386+8192)>>14 = 1; input -2 → -1.
- Handshake/writes: coef_wr_en during MAC is dropped (readback via impulse unchanged); sample_valid while busy is not accepted; a same-cycle write+sample uses the new h.
- Bypass and reset: bypass=1 gives output equal to input at +1 cycle; asserting rst mid-MAC gives no out_valid, all outputs 0, and h restored to identity.

Source files
------------

// File: rtl/fir_pkg.sv
// ============================================================================
// fir_pkg : shared FSM encoding, width helpers and round/saturate for the FIR.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    localparam int DEFAULT_FRAC_BITS = 14;

    // Wide enough for the full dot product of TAPS signed products.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Coefficient value representing 1.0 (identity filter tap).
    function automatic logic signed [63:0] unity_coef(input int frac_bits);
        return 64'sd1 <<< frac_bits;
    endfunction

    // Round half-up, drop the fractional bits, then clamp to the sample range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int frac_bits,
                                                     input int data_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (frac_bits > 0) begin
            r = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        end
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac_unit.sv
// ============================================================================
// fir_mac_unit : signed multiply-accumulate with clear and rounded/saturated
//                view of the running sum including the current product.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 14,
    parameter int ACC_W     = 36
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [DATA_W-1:0] result_o
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    assign prod = PROD_W'(sample_i) * PROD_W'(coef_i);
    assign sum  = acc_q + ACC_W'(prod);

    // Clear wins over accumulate so the last tap of a channel restarts at zero.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result_o = DATA_W'(round_sat(64'(sum), FRAC_BITS, DATA_W));

endmodule

`default_nettype wire

// File: rtl/fir_filter_mac.sv
// ============================================================================
// fir_filter_mac : time-multiplexed multi-channel FIR with one shared MAC,
//                  run-time loadable coefficients and a bypass path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_filter_mac
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
    parameter int TAPS      = 9,
    parameter int CHANNELS  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sample_valid_i,
    output logic                         sample_ready_o,
    input  logic [CHANNELS*DATA_W-1:0]   sample_in_i,
    output logic                         out_valid_o,
    output logic [CHANNELS*DATA_W-1:0]   sample_out_o,
    input  logic                         bypass_i,
    input  logic                         coef_wr_en_i,
    input  logic [$clog2(TAPS)-1:0]      coef_wr_addr_i,
    input  logic [COEF_W-1:0]            coef_wr_data_i
);

    localparam int TAP_W = $clog2(TAPS);
    localparam int CH_W  = idx_width(CHANNELS);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

    fir_state_e                state_q;
    logic [TAP_W-1:0]          tap_q;
    logic [CH_W-1:0]           ch_q;
    logic                      ready_q;
    logic                      out_valid_q;

    logic signed [DATA_W-1:0]  dly_q [CHANNELS][TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [DATA_W-1:0]  res_q [CHANNELS];
    logic signed [DATA_W-1:0]  res_d [CHANNELS];
    logic [CHANNELS*DATA_W-1:0] sample_out_q;
    logic [CHANNELS*DATA_W-1:0] sample_out_d;

    logic                      accept;
    logic                      coef_we;
    logic                      in_mac;
    logic                      last_tap;
    logic                      last_ch;
    logic                      mac_clear;
    logic signed [DATA_W-1:0]  mac_result;

    assign accept    = sample_valid_i & ready_q;
    assign in_mac    = (state_q == ST_MAC);
    assign last_tap  = (tap_q == TAP_W'(TAPS - 1));
    assign last_ch   = (ch_q == CH_W'(CHANNELS - 1));
    assign mac_clear = accept | (in_mac & last_tap);
    assign coef_we   = coef_wr_en_i & (state_q == ST_IDLE) & (int'(coef_wr_addr_i) < TAPS);

    fir_mac_unit #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (mac_clear),
        .en_i     (in_mac),
        .sample_i (dly_q[ch_q][tap_q]),
        .coef_i   (coef_q[tap_q]),
        .result_o (mac_result)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            ch_q        <= '0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        tap_q   <= '0;
                        ch_q    <= '0;
                        if (bypass_i) begin
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_MAC;
                        end
                    end
                end
                ST_MAC: begin
                    if (last_tap) begin
                        tap_q <= '0;
                        if (last_ch) begin
                            ch_q        <= '0;
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                        end else begin
                            ch_q <= ch_q + CH_W'(1);
                        end
                    end else begin
                        tap_q <= tap_q + TAP_W'(1);
                    end
                end
                ST_OUT: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // The last channel's result goes straight to the output so that the
    // published frame changes on exactly the edge that raises out_valid.
    always_comb begin
        res_d        = res_q;
        sample_out_d = sample_out_q;
        if (in_mac && last_tap) begin
            res_d[ch_q] = mac_result;
        end
        if (in_mac && last_tap && last_ch) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sample_out_d[(CHANNELS-1-c)*DATA_W +: DATA_W] = res_d[c];
            end
        end
        if (accept && bypass_i) begin
            sample_out_d = sample_in_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < CHANNELS; c++) begin
                res_q[c] <= '0;
                for (int k = 0; k < TAPS; k++) begin
                    dly_q[c][k] <= '0;
                end
            end
            coef_q[0] <= COEF_W'(unity_coef(FRAC_BITS));
            for (int k = 1; k < TAPS; k++) begin
                coef_q[k] <= '0;
            end
            sample_out_q <= '0;
        end else begin
            // A write in the accepting cycle lands before the MAC reads the bank.
            if (coef_we) begin
                for (int k = 0; k < TAPS; k++) begin
                    if (coef_wr_addr_i == TAP_W'(k)) begin
                        coef_q[k] <= coef_wr_data_i;
                    end
                end
            end
            if (accept) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int k = TAPS - 1; k > 0; k--) begin
                        dly_q[c][k] <= dly_q[c][k-1];
                    end
                    dly_q[c][0] <= sample_in_i[(CHANNELS-1-c)*DATA_W +: DATA_W];
                end
            end
            res_q        <= res_d;
            sample_out_q <= sample_out_d;
        end
    end

    assign sample_ready_o = ready_q;
    assign out_valid_o    = out_valid_q;
    assign sample_out_o   = sample_out_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_filter_mac.sv
// ============================================================================
// tb_fir_filter_mac : randomized self-checking bench with a dot-product model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_filter_mac;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int FRAC_BITS = 14;
    localparam int TAPS      = 9;
    localparam int CHANNELS  = 2;
    localparam int TAP_W     = $clog2(TAPS);

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       sample_valid = 1'b0;
    logic                       sample_ready;
    logic [CHANNELS*DATA_W-1:0] sample_in = '0;
    logic                       out_valid;
    logic [CHANNELS*DATA_W-1:0] sample_out;
    logic                       bypass = 1'b0;
    logic                       coef_wr_en = 1'b0;
    logic [TAP_W-1:0]           coef_wr_addr = '0;
    logic [COEF_W-1:0]          coef_wr_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    longint mx [CHANNELS][TAPS];
    longint mh [TAPS];

    always #5 clk = ~clk;

    fir_filter_mac #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .FRAC_BITS (FRAC_BITS),
        .TAPS      (TAPS),
        .CHANNELS  (CHANNELS)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sample_valid_i (sample_valid),
        .sample_ready_o (sample_ready),
        .sample_in_i    (sample_in),
        .out_valid_o    (out_valid),
        .sample_out_o   (sample_out),
        .bypass_i       (bypass),
        .coef_wr_en_i   (coef_wr_en),
        .coef_wr_addr_i (coef_wr_addr),
        .coef_wr_data_i (coef_wr_data)
    );

    task automatic check_value(input string tag, input logic signed [63:0] got,
                               input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++) mx[c][k] = 0;
        for (int k = 0; k < TAPS; k++) mh[k] = 0;
        mh[0] = longint'(1) << FRAC_BITS;
    endfunction

    function automatic void model_push(input longint d0, input longint d1);
        for (int c = 0; c < CHANNELS; c++)
            for (int k = TAPS - 1; k > 0; k--) mx[c][k] = mx[c][k-1];
        mx[0][0] = d0;
        mx[1][0] = d1;
    endfunction

    function automatic longint model_y(input int c);
        longint s;
        longint hi;
        longint lo;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += mh[k] * mx[c][k];
        s = (s + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
        hi = (longint'(1) << (DATA_W - 1)) - 1;
        lo = -(longint'(1) << (DATA_W - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    function automatic longint rand_s16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return longint'(v);
    endfunction

    task automatic write_coef(input int addr, input longint data);
        @(negedge clk);
        coef_wr_en   = 1'b1;
        coef_wr_addr = TAP_W'(addr);
        coef_wr_data = COEF_W'(data);
        @(posedge clk); #1;
        coef_wr_en = 1'b0;
        if (addr < TAPS) mh[addr] = longint'($signed(COEF_W'(data)));
    endtask

    // poke: 0 none, 1 valid while busy, 2 coefficient write while busy
    task automatic run_frame(input longint d0, input longint d1, input bit byp,
                             input bit wr, input int waddr, input longint wdata,
                             input int poke);
        logic [CHANNELS*DATA_W-1:0] held;
        bit     moved;
        int     lat;
        longint e0;
        longint e1;
        @(negedge clk);
        check_value("ready_idle", sample_ready, 1);
        held         = sample_out;
        sample_valid = 1'b1;
        sample_in    = {DATA_W'(d0), DATA_W'(d1)};
        bypass       = byp;
        if (wr) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = TAP_W'(waddr);
            coef_wr_data = COEF_W'(wdata);
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        coef_wr_en   = 1'b0;
        bypass       = 1'($urandom);
        sample_in    = $urandom;
        if (wr && waddr < TAPS) mh[waddr] = longint'($signed(COEF_W'(wdata)));
        model_push(d0, d1);
        if (byp) begin
            e0 = d0;
            e1 = d1;
        end else begin
            e0 = model_y(0);
            e1 = model_y(1);
        end
        lat   = 1;
        moved = 0;
        while (!out_valid && lat < 40) begin
            if (sample_out !== held) moved = 1;
            if (lat == 5 && poke == 1) begin
                sample_valid = 1'b1;
                sample_in    = $urandom;
            end
            if (lat == 5 && poke == 2) begin
                coef_wr_en   = 1'b1;
                coef_wr_addr = TAP_W'($urandom_range(TAPS - 1, 0));
                coef_wr_data = COEF_W'($urandom);
            end
            @(posedge clk); #1;
            sample_valid = 1'b0;
            coef_wr_en   = 1'b0;
            lat++;
        end
        check_value("latency", lat, byp ? 1 : TAPS * CHANNELS + 1);
        check_value("out_hold", moved, 0);
        check_value("ch0", $signed(sample_out[2*DATA_W-1:DATA_W]), e0);
        check_value("ch1", $signed(sample_out[DATA_W-1:0]), e1);
        @(posedge clk); #1;
        check_value("valid_pulse", out_valid, 0);
        check_value("ready_back", sample_ready, 1);
    endtask

    initial begin
        bit seen;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ready", sample_ready, 1);
        check_value("rst_valid", out_valid, 0);
        check_value("rst_out", sample_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(1000, -1000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) run_frame(rand_s16(), rand_s16(), 0, 0, 0, 0, 0);

        for (int k = 0; k < TAPS; k++) write_coef(k, k * 1024);
        run_frame(16384, rand_s16(), 0, 0, 0, 0, 0);
        for (int i = 0; i < TAPS + 1; i++) run_frame(0, 0, 0, 0, 0, 0, (i % 3 == 1) ? 2 : (i % 3));

        for (int k = 0; k < TAPS; k++) write_coef(k, 16384);
        for (int i = 0; i < TAPS; i++) run_frame(32767, -32768, 0, 0, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) run_frame(-32768, 32767, 0, 0, 0, 0, 0);

        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
        write_coef(0, 8193);
        run_frame(2, -2, 0, 0, 0, 0, 0);
        run_frame(-2, 2, 0, 0, 0, 0, 0);

        run_frame(1000, -3000, 0, 1, 0, 4096, 0);
        write_coef(TAPS + 1, 12345);
        run_frame(rand_s16(), rand_s16(), 0, 1, TAPS, 777, 0);
        run_frame(4321, -4321, 1, 0, 0, 0, 0);
        run_frame(rand_s16(), rand_s16(), 0, 0, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3, 0) == 0)
                write_coef($urandom_range(15, 0), rand_s16());
            if ($urandom_range(3, 0) == 0)
                run_frame(rand_s16(), rand_s16(), 1, 0, 0, 0, 0);
            else
                run_frame(rand_s16(), rand_s16(), 0, 1'($urandom),
                          $urandom_range(15, 0), rand_s16(), $urandom_range(2, 0));
        end

        @(negedge clk);
        sample_valid = 1'b1;
        bypass       = 1'b0;
        sample_in    = {16'sd5000, 16'sd6000};
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_value("abort_valid", out_valid, 0);
        check_value("abort_out", sample_out, 0);
        check_value("abort_ready", sample_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check_value("abort_no_valid", seen, 0);
        run_frame(1234, -5678, 0, 0, 0, 0, 0);
        run_frame(rand_s16(), rand_s16(), 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
